// File: rtl/gaussian_filter_5x5.sv
// Streaming 5x5 binomial (Gaussian) smoothing filter for 5-bit pixels.
// One column of five pixels enters per clock; the window slides horizontally.
module gaussian_filter_5x5 (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] pixel_in1,
    input  logic [4:0] pixel_in2,
    input  logic [4:0] pixel_in3,
    input  logic [4:0] pixel_in4,
    input  logic [4:0] pixel_in5,
    input  logic       enable,
    output logic [4:0] pixel_out,
    output logic       readable
);

    // Column packing: bits [5r+4:5r] hold row r (row 0 = pixel_in1).
    logic [24:0] col_r [0:3];
    logic [24:0] in_col_s;
    logic [8:0]  vsum_s [0:4];
    logic [4:0]  pixel_s;

    // Vertical {1,4,6,4,1} tap of one column, shift-add only; max 31*16 = 496.
    function automatic logic [8:0] vert_tap(input logic [24:0] col);
        logic [8:0] p0;
        logic [8:0] p1;
        logic [8:0] p2;
        logic [8:0] p3;
        logic [8:0] p4;
        p0 = {4'd0, col[4:0]};
        p1 = {4'd0, col[9:5]};
        p2 = {4'd0, col[14:10]};
        p3 = {4'd0, col[19:15]};
        p4 = {4'd0, col[24:20]};
        return p0 + (p1 << 2) + (p2 << 2) + (p2 << 1) + (p3 << 2) + p4;
    endfunction

    // Horizontal {1,4,6,4,1} tap of the five column sums, then floor divide by 256.
    function automatic logic [4:0] horiz_tap(input logic [8:0] c0, input logic [8:0] c1,
                                             input logic [8:0] c2, input logic [8:0] c3,
                                             input logic [8:0] c4);
        logic [12:0] s0;
        logic [12:0] s1;
        logic [12:0] s2;
        logic [12:0] s3;
        logic [12:0] s4;
        logic [12:0] sum;
        s0  = {4'd0, c0};
        s1  = {4'd0, c1};
        s2  = {4'd0, c2};
        s3  = {4'd0, c3};
        s4  = {4'd0, c4};
        sum = s0 + (s1 << 2) + (s2 << 2) + (s2 << 1) + (s3 << 2) + s4;
        return sum[12:8];
    endfunction

    assign in_col_s  = {pixel_in5, pixel_in4, pixel_in3, pixel_in2, pixel_in1};
    assign vsum_s[0] = vert_tap(col_r[0]);
    assign vsum_s[1] = vert_tap(col_r[1]);
    assign vsum_s[2] = vert_tap(col_r[2]);
    assign vsum_s[3] = vert_tap(col_r[3]);
    assign vsum_s[4] = vert_tap(in_col_s);
    assign pixel_s   = horiz_tap(vsum_s[0], vsum_s[1], vsum_s[2], vsum_s[3], vsum_s[4]);

    // Window shift (col_r[0] oldest) and registered filter output / valid flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_r[0]  <= 25'd0;
            col_r[1]  <= 25'd0;
            col_r[2]  <= 25'd0;
            col_r[3]  <= 25'd0;
            pixel_out <= 5'd0;
            readable  <= 1'b0;
        end else begin
            col_r[0]  <= col_r[1];
            col_r[1]  <= col_r[2];
            col_r[2]  <= col_r[3];
            col_r[3]  <= in_col_s;
            pixel_out <= pixel_s;
            readable  <= enable;
        end
    end

endmodule

// File: tb/tb_gaussian_filter_5x5.sv
// Self-checking bench for gaussian_filter_5x5 against a column-history reference model.
module tb_gaussian_filter_5x5;

    logic       clk;
    logic       reset;
    logic [4:0] pixel_in1;
    logic [4:0] pixel_in2;
    logic [4:0] pixel_in3;
    logic [4:0] pixel_in4;
    logic [4:0] pixel_in5;
    logic       enable;
    logic [4:0] pixel_out;
    logic       readable;

    int checks   = 0;
    int failures = 0;
    int last_exp = 0;
    int bw [5]   = '{1, 4, 6, 4, 1};

    // Every column the filter has accepted since the last reset; index [r] = row r.
    logic [4:0][4:0] hist [$];

    gaussian_filter_5x5 dut (
        .clk       (clk),
        .reset     (reset),
        .pixel_in1 (pixel_in1),
        .pixel_in2 (pixel_in2),
        .pixel_in3 (pixel_in3),
        .pixel_in4 (pixel_in4),
        .pixel_in5 (pixel_in5),
        .enable    (enable),
        .pixel_out (pixel_out),
        .readable  (readable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ref_pixel();
        int sum = 0;
        int n   = hist.size();
        for (int c = 0; c < 5; c++)
            for (int r = 0; r < 5; r++)
                sum += int'(hist[n - 5 + c][r]) * bw[r] * bw[c];
        return sum / 256;
    endfunction

    function automatic logic [4:0][4:0] uni_col(input logic [4:0] v);
        logic [4:0][4:0] col;
        for (int r = 0; r < 5; r++) col[r] = v;
        return col;
    endfunction

    function automatic logic [4:0][4:0] rand_col();
        logic [4:0][4:0] col;
        for (int r = 0; r < 5; r++) col[r] = 5'($urandom_range(0, 31));
        return col;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 4; i++) hist.push_back(uni_col(5'd0));
    endtask

    // One clock: drive a column, then check readable and (when enabled) pixel_out.
    task automatic step(input logic [4:0][4:0] col, input logic en, input string tag);
        @(negedge clk);
        reset     = 1'b0;
        pixel_in1 = col[0];
        pixel_in2 = col[1];
        pixel_in3 = col[2];
        pixel_in4 = col[3];
        pixel_in5 = col[4];
        enable    = en;
        @(posedge clk);
        hist.push_back(col);
        last_exp = ref_pixel();
        #1;
        checks++;
        if (readable !== en) begin
            failures++;
            $display("FAIL %s readable: got %b want %b", tag, readable, en);
        end
        if (en) begin
            checks++;
            if (pixel_out !== 5'(last_exp)) begin
                failures++;
                $display("FAIL %s pixel_out: got %0d want %0d", tag, pixel_out, last_exp);
            end
        end
    endtask

    // Reset edge; reset stays high until the next step releases it.
    task automatic do_reset(input logic en, input string tag);
        @(negedge clk);
        reset  = 1'b1;
        enable = en;
        @(posedge clk);
        model_reset();
        #1;
        checks++;
        if (readable !== 1'b0 || pixel_out !== 5'd0) begin
            failures++;
            $display("FAIL %s: got readable=%b pixel_out=%0d want 0/0", tag, readable, pixel_out);
        end
    endtask

    task automatic test_reset();
        do_reset(1'b1, "reset");
    endtask

    task automatic test_constant(input logic [4:0] v);
        for (int i = 0; i < 4; i++) step(uni_col(v), 1'b0, "const_prime");
        for (int i = 0; i < 100; i++) begin
            step(uni_col(v), 1'b1, "const");
            checks++;
            if (pixel_out !== v) begin
                failures++;
                $display("FAIL const_value: got %0d want %0d", pixel_out, v);
            end
        end
    endtask

    task automatic test_impulse();
        logic [4:0][4:0] imp;
        int exp_seq [6] = '{0, 2, 4, 2, 0, 0};
        imp    = uni_col(5'd0);
        imp[2] = 5'd31;
        for (int i = 0; i < 4; i++) step(uni_col(5'd0), 1'b0, "imp_prime");
        for (int i = 0; i < 6; i++) begin
            step((i == 0) ? imp : uni_col(5'd0), 1'b1, "impulse");
            checks++;
            if (pixel_out !== 5'(exp_seq[i])) begin
                failures++;
                $display("FAIL impulse_seq[%0d]: got %0d want %0d", i, pixel_out, exp_seq[i]);
            end
        end
    endtask

    task automatic test_enable_gating();
        for (int i = 0; i < 8; i++) step(rand_col(), 1'b0, "gate_off");
        step(rand_col(), 1'b1, "gate_pulse");
        for (int i = 0; i < 4; i++) step(rand_col(), 1'b0, "gate_after");
    endtask

    task automatic test_truncation();
        logic [4:0][4:0] col;
        for (int c = 0; c < 5; c++) begin
            col = uni_col(5'd1);
            if (c == 2) col[2] = 5'd2;
            step(col, (c == 4), "trunc_292");
        end
        checks++;
        if (pixel_out !== 5'd1) begin
            failures++;
            $display("FAIL trunc_292: got %0d want 1", pixel_out);
        end
        for (int c = 0; c < 5; c++) begin
            col = uni_col(5'd30);
            if (c == 0) col[0] = 5'd31;
            step(col, (c == 4), "trunc_7681");
        end
        checks++;
        if (pixel_out !== 5'd30) begin
            failures++;
            $display("FAIL trunc_7681: got %0d want 30", pixel_out);
        end
    endtask

    task automatic test_midstream_reset();
        for (int i = 0; i < 4; i++) step(uni_col(5'd31), 1'b0, "mid_prime");
        for (int i = 0; i < 3; i++) step(uni_col(5'd31), 1'b1, "mid_stream");
        do_reset(1'b1, "mid_reset");
        for (int i = 0; i < 4; i++) step(rand_col(), 1'b0, "mid_reprime");
        for (int i = 0; i < 6; i++) step(rand_col(), 1'b1, "mid_after");
    endtask

    task automatic test_random_stream();
        for (int i = 0; i < 4; i++) step(rand_col(), 1'b0, "rand_prime");
        for (int i = 0; i < 100; i++) step(rand_col(), 1'b1, "rand");
    endtask

    initial begin
        reset     = 1'b0;
        enable    = 1'b0;
        pixel_in1 = 5'd0;
        pixel_in2 = 5'd0;
        pixel_in3 = 5'd0;
        pixel_in4 = 5'd0;
        pixel_in5 = 5'd0;
        test_reset();
        test_constant(5'd31);
        test_constant(5'd10);
        test_impulse();
        test_enable_gating();
        test_truncation();
        test_midstream_reset();
        test_random_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
